jump_button_conditioner: RTL and testbench



---
 rtl/io_pkg.sv | 12 +
 rtl/sync_2ff.sv | 22 ++
 rtl/jump_button_conditioner.sv | 97 +++++++++
 tb/tb_jump_button_conditioner.sv | 136 +++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: board-level constants shared by the I/O conditioning blocks
package io_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 5;

    // Converts a duration in milliseconds into a count of system clock cycles
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit, reset to 0
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    // Two back-to-back flops give the first stage a full cycle to settle
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/jump_button_conditioner.sv
// jump_button_conditioner: synchronizes, debounces and latches the jump button as a sticky request
module jump_button_conditioner
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int COUNT_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               button_in,
    input  logic               jump_ack,
    output logic               io_jump,
    output logic               pressed,
    output logic [COUNT_W-1:0] press_count
);

    typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

    // A single-cycle debounce accepts a change immediately, skipping the wait states
    localparam bit             ONE  = (DEBOUNCE_CYCLES == 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             press;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (button_in),
        .q     (s)
    );

    // Press fires on the same edge the FSM enters HIGH, so request and count line up with pressed
    always_comb press = s && ((state == LOW && ONE) || (state == WAIT_HIGH && cnt == LAST));

    // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES stable samples
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= LOW;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            case (state)
                LOW: if (s) begin
                    state   <= ONE ? HIGH : WAIT_HIGH;
                    cnt     <= ONE ? '0 : CNT_W'(1);
                    pressed <= ONE;
                end
                WAIT_HIGH: if (!s) begin
                    state <= LOW;
                    cnt   <= '0;
                end else if (cnt == LAST) begin
                    state   <= HIGH;
                    cnt     <= '0;
                    pressed <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                HIGH: if (!s) begin
                    state   <= ONE ? LOW : WAIT_LOW;
                    cnt     <= ONE ? '0 : CNT_W'(1);
                    pressed <= !ONE;
                end
                WAIT_LOW: if (s) begin
                    state <= HIGH;
                    cnt   <= '0;
                end else if (cnt == LAST) begin
                    state   <= LOW;
                    cnt     <= '0;
                    pressed <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                    state   <= LOW;
                    cnt     <= '0;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

    // Sticky request: a press sets it and beats a same-cycle ack; every press is counted
    always_ff @(posedge clock) begin
        if (reset) begin
            io_jump     <= 1'b0;
            press_count <= '0;
        end else begin
            io_jump     <= press | (io_jump & ~jump_ack);
            press_count <= press ? press_count + COUNT_W'(1) : press_count;
        end
    end

endmodule

// File: tb/tb_jump_button_conditioner.sv
// tb_jump_button_conditioner: directed checks of debounce, request latch and press counter
module tb_jump_button_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       button_in = 1'b0;
    logic       jump_ack = 1'b0;
    logic       io_jump;
    logic       pressed;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    jump_button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .button_in   (button_in),
        .jump_ack    (jump_ack),
        .io_jump     (io_jump),
        .pressed     (pressed),
        .press_count (press_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic p, input logic j, input logic [7:0] c);
        check({tag, "_pressed"}, 32'(pressed), 32'(p));
        check({tag, "_io_jump"}, 32'(io_jump), 32'(j));
        check({tag, "_count"}, 32'(press_count), 32'(c));
    endtask

    task automatic press_release();
        button_in = 1'b1;
        repeat (6) tick();
        button_in = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        button_in = 1'b1;
        repeat (3) tick();
        outs("reset", 1'b0, 1'b0, 8'd0);
        button_in = 1'b0;
        reset = 1'b0;
        repeat (4) tick();

        // bounce: high 3, low 1, high 2, low
        button_in = 1'b1; repeat (3) tick();
        button_in = 1'b0; tick();
        button_in = 1'b1; repeat (2) tick();
        check("bounce_mid", 32'(pressed), 32'd0);
        button_in = 1'b0; repeat (8) tick();
        outs("bounce", 1'b0, 1'b0, 8'd0);

        // clean press: nothing through edge k+4, everything after k+5
        button_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("press_early_pressed", 32'(pressed), 32'd0);
            check("press_early_io_jump", 32'(io_jump), 32'd0);
        end
        tick();
        outs("press", 1'b1, 1'b1, 8'd1);

        // release latency; request survives release
        button_in = 1'b0;
        repeat (5) tick();
        check("release_early", 32'(pressed), 32'd1);
        tick();
        outs("release", 1'b0, 1'b1, 8'd1);

        // re-press with ack landing on the press edge: set wins
        button_in = 1'b1;
        repeat (5) tick();
        check("simul_pre", 32'(pressed), 32'd0);
        jump_ack = 1'b1;
        tick();
        jump_ack = 1'b0;
        outs("simul", 1'b1, 1'b1, 8'd2);

        // ack one cycle later clears request, pressed held
        tick();
        jump_ack = 1'b1;
        tick();
        jump_ack = 1'b0;
        outs("ack", 1'b1, 1'b0, 8'd2);

        // ack with nothing pending is ignored
        jump_ack = 1'b1;
        tick();
        jump_ack = 1'b0;
        tick();
        outs("ack_idle", 1'b1, 1'b0, 8'd2);
        button_in = 1'b0;
        repeat (8) tick();

        // wrap: 256 presses from reset without ack
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        outs("reset2", 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 255; i++) press_release();
        outs("wrap_255", 1'b0, 1'b1, 8'd255);
        button_in = 1'b1;
        repeat (6) tick();
        outs("wrap", 1'b1, 1'b1, 8'd0);

        // reset mid-press with the button held, then full re-debounce
        reset = 1'b1;
        repeat (2) tick();
        outs("reset_held", 1'b0, 1'b0, 8'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("rehold_early", 32'(pressed), 32'd0);
        tick();
        outs("rehold", 1'b1, 1'b1, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
